// File: rtl/pcs_tx_encoder_if.sv
// XGMII-side input words and encoded 66-bit block outputs of the 64b/66b transmit encoder.
interface pcs_tx_encoder_if #(
    parameter int LANES = 2,
    parameter int CNT_W = 16
);
    logic [64*LANES-1:0]    txd;
    logic [8*LANES-1:0]     tx_c;
    logic                   tx_valid;
    logic                   err_clr;
    logic [66*LANES-1:0]    enc_data;
    logic                   enc_valid;
    logic [CNT_W*LANES-1:0] err_cnt;

    modport master (
        output txd, tx_c, tx_valid, err_clr,
        input  enc_data, enc_valid, err_cnt
    );

    modport slave (
        input  txd, tx_c, tx_valid, err_clr,
        output enc_data, enc_valid, err_cnt
    );
endinterface

// File: rtl/pcs_tx_encoder.sv
// Multi-lane 64b/66b transmit encoder with block sequencing check; 1-cycle registered latency.
// No backpressure: tx_valid=0 acts as a gearbox pause that freezes outputs, state and counters.
module pcs_tx_encoder #(
    parameter int LANES = 2,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    pcs_tx_encoder_if.slave bus
);
    typedef enum logic [2:0] {TX_INIT, TX_C, TX_D, TX_T, TX_E} state_t;
    typedef enum logic [2:0] {T_D, T_C, T_S, T_T, T_E} blk_type_t;
    typedef struct packed {
        blk_type_t   kind;
        logic [65:0] blk;
    } enc_t;

    localparam logic [65:0] EBLOCK   = {{8{7'h1E}}, 8'h1E, 2'b01};
    localparam logic [65:0] IDLE_BLK = 66'h79;

    // Returns {mappable, 7-bit code}.
    function automatic logic [7:0] map_ctrl(input logic [7:0] ch);
        case (ch)
            8'h07:   map_ctrl = {1'b1, 7'h00};
            8'h06:   map_ctrl = {1'b1, 7'h06};
            8'hFE:   map_ctrl = {1'b1, 7'h1E};
            default: map_ctrl = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] term_type(input logic [2:0] p);
        case (p)
            3'd0:    term_type = 8'h87;
            3'd1:    term_type = 8'h99;
            3'd2:    term_type = 8'hAA;
            3'd3:    term_type = 8'hB4;
            3'd4:    term_type = 8'hCC;
            3'd5:    term_type = 8'hD2;
            3'd6:    term_type = 8'hE1;
            default: term_type = 8'hFF;
        endcase
    endfunction

    function automatic enc_t encode(input logic [63:0] d, input logic [7:0] c);
        enc_t        r;
        logic [7:0]  m;
        logic        ctl_ok;
        logic [55:0] ctl;
        logic [55:0] tpl;
        logic        tail_ok;
        r.kind = T_E;
        r.blk  = EBLOCK;
        ctl_ok = 1'b1;
        ctl    = '0;
        for (int k = 0; k < 8; k++) begin
            m             = map_ctrl(d[8*k +: 8]);
            ctl_ok        = ctl_ok & m[7];
            ctl[7*k +: 7] = m[6:0];
        end
        if (c == 8'h00) begin
            r.kind = T_D;
            r.blk  = {d, 2'b10};
        end else if (c == 8'hFF && ctl_ok) begin
            r.kind = T_C;
            r.blk  = {ctl, 8'h1E, 2'b01};
        end else if (c == 8'h01 && d[7:0] == 8'hFB) begin
            r.kind = T_S;
            r.blk  = {d[63:8], 8'h78, 2'b01};
        end else if (c == 8'h01 && d[7:0] == 8'h9C && d[63:32] == 32'h0) begin
            r.kind = T_C;
            r.blk  = {32'h0, d[31:8], 8'h4B, 2'b01};
        end else begin
            // At most one terminate position can match a given control mask.
            for (int p = 0; p < 8; p++) begin
                tail_ok = (c == (8'hFF << p)) && (d[8*p +: 8] == 8'hFD);
                tpl     = '0;
                for (int j = 0; j < 8; j++) begin
                    if (j > p && d[8*j +: 8] != 8'h07) tail_ok = 1'b0;
                end
                for (int j = 0; j < 7; j++) begin
                    if (j < p) tpl[8*j +: 8] = d[8*j +: 8];
                end
                if (tail_ok) begin
                    r.kind = T_T;
                    r.blk  = {tpl, term_type(3'(p)), 2'b01};
                end
            end
        end
        return r;
    endfunction

    function automatic state_t next_state(input state_t s, input blk_type_t t);
        state_t n;
        case (s)
            TX_D: begin
                case (t)
                    T_D:     n = TX_D;
                    T_T:     n = TX_T;
                    default: n = TX_E;
                endcase
            end
            TX_E: begin
                case (t)
                    T_D:     n = TX_D;
                    T_C:     n = TX_C;
                    T_T:     n = TX_T;
                    default: n = TX_E;
                endcase
            end
            default: begin
                case (t)
                    T_C:     n = TX_C;
                    T_S:     n = TX_D;
                    default: n = TX_E;
                endcase
            end
        endcase
        return n;
    endfunction

    state_t                 state_q;
    state_t                 state_nxt;
    logic [66*LANES-1:0]    enc_q;
    logic [66*LANES-1:0]    enc_nxt;
    logic                   vld_q;
    logic [CNT_W*LANES-1:0] cnt_q;
    logic [LANES-1:0]       err_hit;

    // Lanes are chained in time order so lane i sees the state left by lane i-1.
    always_comb begin
        state_t s;
        enc_t   e;
        s       = state_q;
        enc_nxt = '0;
        err_hit = '0;
        for (int i = 0; i < LANES; i++) begin
            e = encode(bus.txd[64*i +: 64], bus.tx_c[8*i +: 8]);
            s = next_state(s, e.kind);
            if (s == TX_E) begin
                enc_nxt[66*i +: 66] = EBLOCK;
                err_hit[i]          = 1'b1;
            end else begin
                enc_nxt[66*i +: 66] = e.blk;
            end
        end
        state_nxt = s;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= TX_INIT;
            enc_q   <= {LANES{IDLE_BLK}};
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            vld_q <= bus.tx_valid;
            if (bus.tx_valid) begin
                state_q <= state_nxt;
                enc_q   <= enc_nxt;
                for (int i = 0; i < LANES; i++) begin
                    if (err_hit[i] && cnt_q[CNT_W*i +: CNT_W] != '1)
                        cnt_q[CNT_W*i +: CNT_W] <= cnt_q[CNT_W*i +: CNT_W] + CNT_W'(1);
                end
            end
            if (bus.err_clr) cnt_q <= '0;
        end
    end

    assign bus.enc_data  = enc_q;
    assign bus.enc_valid = vld_q;
    assign bus.err_cnt   = cnt_q;
endmodule

// File: tb/tb_pcs_tx_encoder.sv
// Randomised and directed check of pcs_tx_encoder against a byte-level behavioural model.
module tb_pcs_tx_encoder;
    localparam int L  = 2;
    localparam int CW = 8;
    localparam logic [65:0] IDLE   = 66'h79;
    localparam logic [65:0] EBLK   = {{8{7'h1E}}, 8'h1E, 2'b01};
    localparam logic [63:0] IDLE_W = 64'h0707070707070707;

    logic clk = 1'b0;
    logic rst_n;

    pcs_tx_encoder_if #(.LANES(L), .CNT_W(CW)) bus ();
    pcs_tx_encoder #(.LANES(L), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: states 0=INIT 1=C 2=D 3=T 4=E; block kinds 0=D 1=C 2=S 3=T 4=E.
    int              m_state;
    int              m_cnt [L];
    logic [66*L-1:0] m_data;
    logic            m_vld;
    int              nxt_tab [5][5] = '{'{4, 1, 2, 4, 4}, '{4, 1, 2, 4, 4}, '{2, 4, 4, 3, 4},
                                        '{4, 1, 2, 4, 4}, '{2, 1, 4, 3, 4}};
    logic [7:0]      t_types [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

    function automatic int ctl7(input logic [7:0] b);
        if (b == 8'h07) return 0;
        if (b == 8'h06) return 6;
        if (b == 8'hFE) return 30;
        return -1;
    endfunction

    task automatic classify(input logic [63:0] w, input logic [7:0] c,
                            output int kind, output logic [65:0] blk);
        logic [7:0]      b [8];
        int              p;
        bit              ok;
        logic [55:0]     chars;
        logic [63:0]     mask;
        for (int k = 0; k < 8; k++) b[k] = w[8*k +: 8];
        kind  = 4;
        blk   = EBLK;
        ok    = 1;
        chars = '0;
        for (int k = 0; k < 8; k++) begin
            if (ctl7(b[k]) < 0) ok = 0;
            else chars = chars | (56'(ctl7(b[k])) << (7*k));
        end
        if (c == 8'h00) begin
            kind = 0;
            blk  = {w, 2'b10};
        end else if (c == 8'hFF && ok) begin
            kind = 1;
            blk  = {chars, 8'h1E, 2'b01};
        end else if (c == 8'h01 && b[0] == 8'hFB) begin
            kind = 2;
            blk  = {w[63:8], 8'h78, 2'b01};
        end else if (c == 8'h01 && b[0] == 8'h9C && w[63:32] == 32'h0) begin
            kind = 1;
            blk  = {32'h0, w[31:8], 8'h4B, 2'b01};
        end else begin
            p = 0;
            while (p < 8 && !c[p]) p++;
            if (p < 8 && c == 8'(8'hFF << p) && b[p] == 8'hFD) begin
                ok = 1;
                for (int j = p + 1; j < 8; j++) if (b[j] != 8'h07) ok = 0;
                if (ok) begin
                    mask = (64'd1 << (8*p)) - 64'd1;
                    kind = 3;
                    blk  = {56'(w & mask), t_types[p], 2'b01};
                end
            end
        end
    endtask

    task automatic model_step(input logic [64*L-1:0] d, input logic [8*L-1:0] c,
                              input logic v, input logic clr, input logic rn);
        int          kind;
        logic [65:0] blk;
        if (!rn) begin
            m_state = 0;
            m_data  = {L{IDLE}};
            m_vld   = 0;
            for (int i = 0; i < L; i++) m_cnt[i] = 0;
        end else begin
            m_vld = v;
            if (v) begin
                for (int i = 0; i < L; i++) begin
                    classify(d[64*i +: 64], c[8*i +: 8], kind, blk);
                    m_state = nxt_tab[m_state][kind];
                    if (m_state == 4) begin
                        m_data[66*i +: 66] = EBLK;
                        if (m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
                    end else begin
                        m_data[66*i +: 66] = blk;
                    end
                end
            end
            if (clr) for (int i = 0; i < L; i++) m_cnt[i] = 0;
        end
    endtask

    task automatic chk(input string nm, input logic [131:0] got, input logic [131:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, exp);
        end
    endtask

    task automatic compare();
        logic [CW*L-1:0] ec;
        for (int i = 0; i < L; i++) ec[CW*i +: CW] = CW'(m_cnt[i]);
        chk("enc_data", 132'(bus.enc_data), 132'(m_data));
        chk("enc_valid", 132'(bus.enc_valid), 132'(m_vld));
        chk("err_cnt", 132'(bus.err_cnt), 132'(ec));
    endtask

    task automatic step(input logic [64*L-1:0] d, input logic [8*L-1:0] c,
                        input logic v, input logic clr, input logic rn);
        bus.txd      = d;
        bus.tx_c     = c;
        bus.tx_valid = v;
        bus.err_clr  = clr;
        rst_n        = rn;
        model_step(d, c, v, clr, rn);
        @(posedge clk);
        #1;
        cyc++;
        compare();
    endtask

    function automatic logic [65:0] lane(input int i);
        return bus.enc_data[66*i +: 66];
    endfunction

    function automatic logic [CW-1:0] cnt_of(input int i);
        return bus.err_cnt[CW*i +: CW];
    endfunction

    function automatic logic [63:0] term_word(input int p, input logic [63:0] r);
        logic [63:0] w;
        w = r;
        for (int j = 0; j < 8; j++) begin
            if (j == p) w[8*j +: 8] = 8'hFD;
            else if (j > p) w[8*j +: 8] = 8'h07;
        end
        return w;
    endfunction

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    task automatic rnd_word(output logic [63:0] w, output logic [7:0] c);
        int p;
        case ($urandom_range(0, 9))
            0, 1: begin w = IDLE_W; c = 8'hFF; end
            2: begin w = {r64()[63:8], 8'hFB}; c = 8'h01; end
            3, 4, 5: begin w = r64(); c = 8'h00; end
            6: begin
                p = $urandom_range(0, 7);
                w = term_word(p, r64());
                c = 8'(8'hFF << p);
            end
            7: begin
                w = {($urandom_range(0, 3) == 0) ? $urandom : 32'h0, r64()[23:0], 8'h9C};
                c = 8'h01;
            end
            8: begin
                c = 8'hFF;
                for (int k = 0; k < 8; k++) begin
                    case ($urandom_range(0, 5))
                        0, 1:    w[8*k +: 8] = 8'h07;
                        2:       w[8*k +: 8] = 8'h06;
                        3:       w[8*k +: 8] = 8'hFE;
                        default: w[8*k +: 8] = 8'($urandom);
                    endcase
                end
            end
            default: begin w = r64(); c = 8'($urandom); end
        endcase
    endtask

    logic [63:0] wa, wb;
    logic [7:0]  ca, cb;
    logic [63:0] bad;

    initial begin
        #5_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "time limit");
    end

    initial begin
        bus.txd = '0; bus.tx_c = '0; bus.tx_valid = 0; bus.err_clr = 0; rst_n = 0;

        step({IDLE_W, IDLE_W}, 16'hFFFF, 1, 1, 0);
        step({IDLE_W, IDLE_W}, 16'hFFFF, 1, 0, 0);
        chk("rst_data", 132'(bus.enc_data), 132'({IDLE, IDLE}));
        chk("rst_valid", 132'(bus.enc_valid), 132'(0));
        chk("rst_cnt", 132'(bus.err_cnt), 132'(0));

        step({IDLE_W, IDLE_W}, 16'hFFFF, 1, 0, 1);
        chk("idle_l0", 132'(lane(0)), 132'(66'h79));
        chk("idle_l1", 132'(lane(1)), 132'(66'h79));
        chk("idle_valid", 132'(bus.enc_valid), 132'(1));

        step({64'h1122334455667788, 64'hD5555555555555FB}, {8'h00, 8'h01}, 1, 0, 1);
        chk("sop_l0", 132'(lane(0)), 132'({56'hD5555555555555, 8'h78, 2'b01}));
        chk("sop_l1", 132'(lane(1)), 132'({64'h1122334455667788, 2'b10}));
        step({IDLE_W, 64'h07070707FDAABBCC}, {8'hFF, 8'hF8}, 1, 0, 1);
        chk("eop_l0", 132'(lane(0)), 132'({32'h0, 24'hAABBCC, 8'hB4, 2'b01}));
        chk("eop_l1", 132'(lane(1)), 132'(66'h79));
        chk("pkt_cnt", 132'(bus.err_cnt), 132'(0));

        step({IDLE_W, 64'hDEADBEEF01234567}, {8'hFF, 8'h00}, 1, 0, 1);
        chk("ill_l0", 132'(lane(0)), 132'(EBLK));
        chk("ill_l1", 132'(lane(1)), 132'(66'h79));
        chk("ill_cnt0", 132'(cnt_of(0)), 132'(1));

        step({64'hA1A2A3A4A5A6A7A8, 64'h0123456789ABCDFB}, {8'h00, 8'h01}, 1, 0, 1);
        repeat (3) begin
            step({r64(), r64()}, 16'($urandom), 0, 0, 1);
            chk("gate_valid", 132'(bus.enc_valid), 132'(0));
            chk("gate_hold", 132'(bus.enc_data),
                132'({64'hA1A2A3A4A5A6A7A8, 2'b10, 56'h0123456789ABCD, 8'h78, 2'b01}));
        end
        step({64'h5566778899AABBCC, 64'h0011223344556677}, 16'h0000, 1, 0, 1);
        chk("gate_resume", 132'(lane(0)), 132'({64'h0011223344556677, 2'b10}));

        step({IDLE_W, IDLE_W}, 16'hFFFF, 1, 0, 0);
        step({64'hCAFEF00DCAFEF00D, 64'h1234567812345678}, 16'h0000, 1, 0, 1);
        chk("rstpkt_l0", 132'(lane(0)), 132'(EBLK));
        chk("rstpkt_l1", 132'(lane(1)), 132'({64'hCAFEF00DCAFEF00D, 2'b10}));
        chk("rstpkt_cnt0", 132'(cnt_of(0)), 132'(1));

        step({IDLE_W, IDLE_W}, 16'hFFFF, 1, 0, 1);
        for (int p = 0; p < 8; p++) begin
            step({r64(), r64()[63:8], 8'hFB}, {8'h00, 8'h01}, 1, 0, 1);
            wa = term_word(p, r64());
            step({IDLE_W, wa}, {8'hFF, 8'(8'hFF << p)}, 1, 0, 1);
            chk("term_type", 132'(lane(0)[9:0]), 132'({t_types[p], 2'b01}));
        end
        chk("term_t0", 132'(lane(0)), 132'({wa[55:0], 8'hFF, 2'b01}));

        bad = 64'h0707070755070707;
        repeat ((1 << CW) + 3) step({IDLE_W, bad}, 16'hFFFF, 1, 0, 1);
        chk("sat_l0", 132'(lane(0)), 132'(EBLK));
        chk("sat_cnt0", 132'(cnt_of(0)), 132'(8'hFF));
        step({IDLE_W, bad}, 16'hFFFF, 1, 1, 1);
        chk("clr_cnt", 132'(bus.err_cnt), 132'(0));

        repeat (3000) begin
            rnd_word(wa, ca);
            rnd_word(wb, cb);
            step({wb, wa}, {cb, ca}, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 99) == 0, $urandom_range(0, 199) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
